rect_overlay_sprite: RTL and testbench
======================================

// Module: rect_overlay_sprite
// PURPOSE
//  Multi-rectangle overlay generator for the pixel pipeline. Draws NUM_RECTS
//  independently configured boxes (off / filled / outlined / blinking fill)
//  with fixed priority, and emits registered RGB plus a hit flag.
//  Sits after hcount/vcount generation and feeds the compositor/mixer.
//  Rectangle configuration is double-buffered so changes never tear mid-frame.
// PARAMETERS
//  NUM_RECTS     4        number of rectangles; index 0 has highest priority
//  COORD_W       12       width of all rectangle coordinates (unsigned)
//  THICKNESS     2        outline thickness in pixels, must be >= 1
//  BLINK_FRAMES  30       frames per blink half-period, must be >= 1
// PORTS
//  clk_pixel_in    in   1          pixel clock
//  rst_in          in   1          asynchronous reset, active-high
//  hcount_in       in   11         current pixel column
//  vcount_in       in   10         current pixel row
//  data_valid_in   in   1          hcount/vcount lie in the active area
//  new_frame_in    in   1          1-cycle pulse at frame start; commits config
//  cfg_valid_in    in   1          config write request
//  cfg_ready_out   out  1          config write accepted when valid&ready
//  cfg_idx_in      in   $clog2(NUM_RECTS)  rectangle being written
//  cfg_xmin_in     in   COORD_W    left edge, inclusive
//  cfg_ymin_in     in   COORD_W    top edge, inclusive
//  cfg_xmax_in     in   COORD_W    right edge, inclusive
//  cfg_ymax_in     in   COORD_W    bottom edge, inclusive
//  cfg_mode_in     in   2          rect_mode_t
//  cfg_color_in    in   24         {R,G,B}
//  red_out/green_out/blue_out  out  8 each  pixel colour, 0 when no hit
//  hit_out         out  1          some rectangle drew this pixel
//  valid_out       out  1          data_valid_in delayed to match outputs
// BEHAVIOUR
//  - Reset (async assert, sync release): shadow and active banks mode=OFF,
//    coords 0, colour 0; blink counter 0, blink_phase 0; all outputs 0;
//    cfg_ready_out 0 while rst_in high, 1 from the first cycle after release.
//  - Config: a write with cfg_valid_in&cfg_ready_out updates shadow[cfg_idx_in]
//    only. cfg_idx_in >= NUM_RECTS: write accepted and dropped.
//  - Commit: on new_frame_in the whole shadow bank is copied to the active
//    bank. Same-cycle write and commit: commit copies the pre-write shadow;
//    the write lands in shadow and shows at the next commit. cfg_ready_out is
//    always 1 outside reset (no backpressure in this revision).
//  - Blink: new_frame_in increments the frame counter; on reaching
//    BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
//  - Hit per rect (active bank, compare width COORD_W+1 to avoid overflow):
//    outer = xmin<=h<=xmax && ymin<=v<=ymax; xmin>xmax or ymin>ymax -> never.
//    FILL: outer. OUTLINE: outer && !(xmin+T<=h<=xmax-T && ymin+T<=v<=ymax-T),
//    inner bounds computed signed; boxes narrower than 2*T+1 draw solid.
//    BLINK: outer && blink_phase. OFF: never.
//  - Priority: lowest-index hitting rectangle supplies the colour.
//  - Pipeline, latency 2 cycles: S1 registers per-rect hit vector + valid;
//    S2 registers priority-select colour, hit_out, valid_out. When the S1
//    valid is 0, S2 forces RGB=0, hit_out=0. Active bank changes take
//    effect for pixels sampled in the cycle after the commit cycle.
// STRUCTURE
//  - Package overlay_pkg: typedef enum logic [1:0] rect_mode_t {MODE_OFF=0,
//    MODE_FILL=1, MODE_OUTLINE=2, MODE_BLINK=3}; packed struct rect_cfg_t
//    {xmin,ymin,xmax,ymax,mode,color}; localparam COLOR_W=24.
//  - Sub-module rect_hit_test: combinational single-rect hit from rect_cfg_t,
//    h, v, blink_phase; instantiated NUM_RECTS times via generate.
// TESTING
//  - Reset mid-frame with rect 0 committed -> next cycle all outputs 0,
//    hit_out 0; after release nothing draws until new config + new_frame_in.
//  - Rect0 FILL (10,10)-(20,15) red, committed -> h=10,v=10 hit, RGB FF0000
//    two cycles later; h=21 or v=9 -> RGB 0, hit_out 0.
//  - Rect1 OUTLINE T=2 (100,100)-(110,110) -> h=101,v=105 hit; h=102,v=105
//    miss; box (100,100)-(103,103) fully solid.
//  - Rect0 green overlapping rect1 blue at (50,50) -> output 00FF00.
//  - Write shadow in same cycle as new_frame_in -> old config drawn this
//    frame, new config drawn after the following new_frame_in.
//  - BLINK_FRAMES=2, BLINK rect -> hidden frames 0-1, drawn frames 2-3, etc.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types for the rectangle overlay: box modes and the per-rectangle
// configuration record held in the shadow and active banks.
package overlay_pkg;

    localparam int unsigned COLOR_W     = 24;
    localparam int unsigned CFG_COORD_W = 12;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_FILL    = 2'd1,
        MODE_OUTLINE = 2'd2,
        MODE_BLINK   = 2'd3
    } rect_mode_t;

    typedef struct packed {
        logic [CFG_COORD_W-1:0] xmin;
        logic [CFG_COORD_W-1:0] ymin;
        logic [CFG_COORD_W-1:0] xmax;
        logic [CFG_COORD_W-1:0] ymax;
        rect_mode_t             mode;
        logic [COLOR_W-1:0]     color;
    } rect_cfg_t;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational hit test of one pixel against one rectangle configuration.
// Coordinates are compared one bit wider than stored so edges never overflow.
module rect_hit_test
    import overlay_pkg::*;
#(
    parameter int unsigned THICKNESS = 2
) (
    input  rect_cfg_t              cfg,
    input  logic [CFG_COORD_W:0]   h,
    input  logic [CFG_COORD_W:0]   v,
    input  logic                   blink_phase,
    output logic                   hit
);

    localparam int unsigned SW = CFG_COORD_W + 2;
    localparam logic signed [SW-1:0] T_S = SW'(THICKNESS);

    logic                 outer;
    logic                 inner;
    logic signed [SW-1:0] h_s, v_s;
    logic signed [SW-1:0] ix_lo, ix_hi, iy_lo, iy_hi;

    // Inverted bounds (min > max) make outer false by construction.
    assign outer = (h >= {1'b0, cfg.xmin}) && (h <= {1'b0, cfg.xmax}) &&
                   (v >= {1'b0, cfg.ymin}) && (v <= {1'b0, cfg.ymax});

    assign h_s   = signed'({1'b0, h});
    assign v_s   = signed'({1'b0, v});
    assign ix_lo = signed'({2'b00, cfg.xmin}) + T_S;
    assign ix_hi = signed'({2'b00, cfg.xmax}) - T_S;
    assign iy_lo = signed'({2'b00, cfg.ymin}) + T_S;
    assign iy_hi = signed'({2'b00, cfg.ymax}) - T_S;

    // An empty interior (narrow box) leaves inner false, so the box draws solid.
    assign inner = (h_s >= ix_lo) && (h_s <= ix_hi) && (v_s >= iy_lo) && (v_s <= iy_hi);

    always_comb begin
        hit = 1'b0;
        case (cfg.mode)
            MODE_FILL:    hit = outer;
            MODE_OUTLINE: hit = outer && !inner;
            MODE_BLINK:   hit = outer && blink_phase;
            default:      hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/rect_overlay_sprite.sv
// Multi-rectangle overlay with double-buffered config, frame-based blinking
// and a two-stage pipeline (hit vector, then priority colour select).
module rect_overlay_sprite
    import overlay_pkg::*;
#(
    parameter int unsigned NUM_RECTS    = 4,
    parameter int unsigned COORD_W      = CFG_COORD_W,
    parameter int unsigned THICKNESS    = 2,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned IDX_W       = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic               clk_pixel_in,
    input  logic               rst_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               data_valid_in,
    input  logic               new_frame_in,
    input  logic               cfg_valid_in,
    output logic               cfg_ready_out,
    input  logic [IDX_W-1:0]   cfg_idx_in,
    input  logic [COORD_W-1:0] cfg_xmin_in,
    input  logic [COORD_W-1:0] cfg_ymin_in,
    input  logic [COORD_W-1:0] cfg_xmax_in,
    input  logic [COORD_W-1:0] cfg_ymax_in,
    input  rect_mode_t         cfg_mode_in,
    input  logic [COLOR_W-1:0] cfg_color_in,
    output logic [7:0]         red_out,
    output logic [7:0]         green_out,
    output logic [7:0]         blue_out,
    output logic               hit_out,
    output logic               valid_out
);

    localparam int unsigned CMP_W = COORD_W + 1;
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    rect_cfg_t          shadow_q [NUM_RECTS];
    rect_cfg_t          active_q [NUM_RECTS];
    rect_cfg_t          wr_cfg;
    logic [CNT_W-1:0]   blink_cnt_q;
    logic               blink_phase_q;
    logic [CMP_W-1:0]   h_ext, v_ext;
    logic [NUM_RECTS-1:0] hit_vec;
    logic [NUM_RECTS-1:0] hit_vec_q;
    logic               valid_s1_q;
    logic [COLOR_W-1:0] sel_color;
    logic               sel_any;
    logic [COLOR_W-1:0] rgb_q;
    logic               hit_q;
    logic               valid_q;
    logic               wr_en;

    // No backpressure: writes are always accepted outside reset.
    assign cfg_ready_out = ~rst_in;
    assign wr_en = cfg_valid_in && cfg_ready_out && (int'(cfg_idx_in) < NUM_RECTS);

    assign wr_cfg = '{xmin: cfg_xmin_in, ymin: cfg_ymin_in, xmax: cfg_xmax_in,
                      ymax: cfg_ymax_in, mode: cfg_mode_in, color: cfg_color_in};

    // Commit reads the pre-write shadow because both updates are non-blocking.
    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (new_frame_in) begin
                for (int i = 0; i < NUM_RECTS; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_en) shadow_q[cfg_idx_in] <= wr_cfg;
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (new_frame_in) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign h_ext = CMP_W'(hcount_in);
    assign v_ext = CMP_W'(vcount_in);

    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        rect_hit_test #(
            .THICKNESS (THICKNESS)
        ) u_hit (
            .cfg         (active_q[g]),
            .h           (h_ext),
            .v           (v_ext),
            .blink_phase (blink_phase_q),
            .hit         (hit_vec[g])
        );
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            hit_vec_q  <= '0;
            valid_s1_q <= 1'b0;
        end else begin
            hit_vec_q  <= hit_vec;
            valid_s1_q <= data_valid_in;
        end
    end

    // Walk from the lowest priority upward so index 0 wins last.
    always_comb begin
        sel_color = '0;
        sel_any   = 1'b0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) begin
                sel_color = active_q[i].color;
                sel_any   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            rgb_q   <= '0;
            hit_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= valid_s1_q ? sel_color : '0;
            hit_q   <= valid_s1_q && sel_any;
            valid_q <= valid_s1_q;
        end
    end

    assign red_out   = rgb_q[23:16];
    assign green_out = rgb_q[15:8];
    assign blue_out  = rgb_q[7:0];
    assign hit_out   = hit_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_rect_overlay_sprite.sv
// Directed self-checking bench for rect_overlay_sprite (BLINK_FRAMES=2).
module tb_rect_overlay_sprite;
    import overlay_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        dv = 1'b0;
    logic        nf = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_idx = '0;
    logic [11:0] cfg_xmin = '0, cfg_ymin = '0, cfg_xmax = '0, cfg_ymax = '0;
    rect_mode_t  cfg_mode = MODE_OFF;
    logic [23:0] cfg_color = '0;
    logic [7:0]  red, green, blue;
    logic        hit, vout;

    int checks = 0;
    int errors = 0;

    rect_overlay_sprite #(
        .NUM_RECTS    (4),
        .COORD_W      (12),
        .THICKNESS    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_pixel_in  (clk),
        .rst_in        (rst),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .data_valid_in (dv),
        .new_frame_in  (nf),
        .cfg_valid_in  (cfg_valid),
        .cfg_ready_out (cfg_ready),
        .cfg_idx_in    (cfg_idx),
        .cfg_xmin_in   (cfg_xmin),
        .cfg_ymin_in   (cfg_ymin),
        .cfg_xmax_in   (cfg_xmax),
        .cfg_ymax_in   (cfg_ymax),
        .cfg_mode_in   (cfg_mode),
        .cfg_color_in  (cfg_color),
        .red_out       (red),
        .green_out     (green),
        .blue_out      (blue),
        .hit_out       (hit),
        .valid_out     (vout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input int x0, input int y0, input int x1, input int y1,
                      input rect_mode_t m, input logic [23:0] c, input logic commit);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_xmin  = 12'(x0);
        cfg_ymin  = 12'(y0);
        cfg_xmax  = 12'(x1);
        cfg_ymax  = 12'(y1);
        cfg_mode  = m;
        cfg_color = c;
        nf        = commit;
        @(negedge clk);
        cfg_valid = 1'b0;
        nf        = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        nf = 1'b1;
        @(negedge clk);
        nf = 1'b0;
    endtask

    // Present one pixel, then check the registered result two edges later.
    task automatic probe(input string tag, input int h, input int v, input logic valid,
                         input logic [23:0] exp_rgb, input logic exp_hit);
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        dv     = valid;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        chk({tag, ".rgb"}, {8'h0, red, green, blue}, {8'h0, exp_rgb});
        chk({tag, ".hit"}, {31'h0, hit}, {31'h0, exp_hit});
        chk({tag, ".valid"}, {31'h0, vout}, {31'h0, valid});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", {31'h0, cfg_ready}, 32'h0);
        chk("rst.rgb", {8'h0, red, green, blue}, 32'h0);
        chk("rst.hit", {31'h0, hit}, 32'h0);
        chk("rst.valid", {31'h0, vout}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel.ready", {31'h0, cfg_ready}, 32'h1);

        // Filled box with edges
        wr(0, 10, 10, 20, 15, MODE_FILL, 24'hFF0000, 1'b0);
        frame();
        probe("fill.tl", 10, 10, 1'b1, 24'hFF0000, 1'b1);
        probe("fill.br", 20, 15, 1'b1, 24'hFF0000, 1'b1);
        probe("fill.h21", 21, 10, 1'b1, 24'h000000, 1'b0);
        probe("fill.v9", 10, 9, 1'b1, 24'h000000, 1'b0);
        probe("fill.novalid", 12, 12, 1'b0, 24'h000000, 1'b0);

        // Outline, thickness 2
        wr(1, 100, 100, 110, 110, MODE_OUTLINE, 24'h0000FF, 1'b0);
        frame();
        probe("outl.edge", 101, 105, 1'b1, 24'h0000FF, 1'b1);
        probe("outl.inner", 102, 105, 1'b1, 24'h000000, 1'b0);
        probe("outl.corner", 100, 100, 1'b1, 24'h0000FF, 1'b1);
        wr(1, 100, 100, 103, 103, MODE_OUTLINE, 24'h0000FF, 1'b0);
        frame();
        probe("outl.small1", 101, 101, 1'b1, 24'h0000FF, 1'b1);
        probe("outl.small2", 102, 102, 1'b1, 24'h0000FF, 1'b1);

        // Overlap priority
        wr(0, 40, 40, 60, 60, MODE_FILL, 24'h00FF00, 1'b0);
        wr(1, 45, 45, 70, 70, MODE_FILL, 24'h0000FF, 1'b0);
        frame();
        probe("prio.both", 50, 50, 1'b1, 24'h00FF00, 1'b1);
        probe("prio.r1", 65, 65, 1'b1, 24'h0000FF, 1'b1);

        // Write in the same cycle as the commit
        wr(0, 200, 200, 210, 210, MODE_FILL, 24'hFFFFFF, 1'b1);
        probe("same.new", 205, 205, 1'b1, 24'h000000, 1'b0);
        probe("same.old", 50, 50, 1'b1, 24'h00FF00, 1'b1);
        frame();
        probe("next.new", 205, 205, 1'b1, 24'hFFFFFF, 1'b1);
        probe("next.old", 50, 50, 1'b1, 24'h0000FF, 1'b1);

        // Reset mid-frame with a pixel in flight
        @(negedge clk);
        hcount = 11'd205;
        vcount = 10'd205;
        dv     = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid.rgb", {8'h0, red, green, blue}, 32'h0);
        chk("mid.hit", {31'h0, hit}, 32'h0);
        chk("mid.valid", {31'h0, vout}, 32'h0);
        chk("mid.ready", {31'h0, cfg_ready}, 32'h0);
        @(negedge clk);
        dv  = 1'b0;
        rst = 1'b0;
        probe("postrst", 205, 205, 1'b1, 24'h000000, 1'b0);
        frame();
        probe("postrst.commit", 205, 205, 1'b1, 24'h000000, 1'b0);

        // Blink: fresh reset so the frame counter starts at 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(2, 300, 300, 310, 310, MODE_BLINK, 24'h123456, 1'b0);
        frame();
        probe("blink.f1", 305, 305, 1'b1, 24'h000000, 1'b0);
        frame();
        probe("blink.f2", 305, 305, 1'b1, 24'h123456, 1'b1);
        frame();
        probe("blink.f3", 305, 305, 1'b1, 24'h123456, 1'b1);
        frame();
        probe("blink.f4", 305, 305, 1'b1, 24'h000000, 1'b0);
        frame();
        probe("blink.f5", 305, 305, 1'b1, 24'h000000, 1'b0);
        frame();
        probe("blink.f6", 305, 305, 1'b1, 24'h123456, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
